// File: rtl/regfile_pkg.sv
// Shared constants, address type and popcount helper for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Widest busy vector popcount can handle; NREGS must not exceed this.
  localparam int MAX_REGS  = 256;

  typedef logic [AW_DEF-1:0] reg_addr_t;

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets a register busy, writeback clears it, and a same-edge set beats the clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] clr_i,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [NREGS-1:0]    busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [MAX_REGS-1:0] busy_pad;

  // A new producer supersedes the result being written back; r0 can never be busy.
  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (set_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    busy_pad = '0;
    busy_pad[NREGS-1:0] = busy_d;
    cnt_d = (AW+1)'(popcount(busy_pad));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write arbitration, optional write-to-read bypass
// and an attached busy scoreboard for RAW hazard stalls.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREGS  = NREGS_DEF,
  parameter int  NRD    = 2,
  parameter int  NWR    = 2,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                set_busy,
  input  logic [AW-1:0]       set_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] wr_clr;
  logic [NREGS-1:0] busy;

  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
  always_comb begin
    regs_d = regs_q;
    wr_clr = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && (wr_addr[p*AW +: AW] != '0)) begin
        regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        wr_clr[wr_addr[p*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (wr_clr),
    .set_i      (set_busy),
    .set_addr_i (set_addr),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] raddr;
    assign raddr = rd_addr[i*AW +: AW];

    if (BYPASS != 0) begin : g_byp
      logic            hit;
      logic [XLEN-1:0] fwd;

      // Forwarded reads show the post-edge busy state: cleared unless re-issued this cycle.
      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && (raddr != '0) && (wr_addr[p*AW +: AW] == raddr)) begin
            hit = 1'b1;
            fwd = wr_data[p*XLEN +: XLEN];
          end
        end
      end

      assign rd_data[i*XLEN +: XLEN] = hit ? fwd : regs_q[raddr];
      assign rd_busy[i] = hit ? (set_busy && (set_addr == raddr)) : busy[raddr];
    end else begin : g_nobyp
      assign rd_data[i*XLEN +: XLEN] = regs_q[raddr];
      assign rd_busy[i] = busy[raddr];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench driving a bypassing and a non-bypassing register file side by side.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        sb;
    logic [4:0]  sa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] b1d0;
    logic [63:0] b1d1;
    logic        b1b0;
    logic        b1b1;
    logic [63:0] b0d0;
    logic [63:0] b0d1;
    logic        b0b0;
    logic        b0b1;
    logic [5:0]  eCnt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   rdAddr;
  logic [1:0]   we;
  logic [9:0]   wrAddr;
  logic [127:0] wrData;
  logic         setBusy;
  reg_addr_t    setAddr;
  logic [127:0] rdData1, rdData0;
  logic [1:0]   rdBusy1, rdBusy0;
  logic [5:0]   cnt1, cnt0;

  int checks = 0;
  int errors = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dutByp (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData1), .rd_busy(rdBusy1),
    .we(we), .wr_addr(wrAddr), .wr_data(wrData), .set_busy(setBusy), .set_addr(setAddr),
    .busy_cnt(cnt1)
  );

  regfile_sb #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dutNoByp (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData0), .rd_busy(rdBusy0),
    .we(we), .wr_addr(wrAddr), .wr_data(wrData), .set_busy(setBusy), .set_addr(setAddr),
    .busy_cnt(cnt0)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we      = v.we;
    wrAddr  = {v.wa1, v.wa0};
    wrData  = {v.wd1, v.wd0};
    setBusy = v.sb;
    setAddr = v.sa;
    rdAddr  = {v.ra1, v.ra0};
  endtask

  task automatic idleInputs();
    we = 2'b00; wrAddr = '0; wrData = '0; setBusy = 1'b0; setAddr = '0;
  endtask

  task automatic checkReads(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                            input logic b0, input logic b1, input logic [5:0] c);
    checkOutput($sformatf("%s byp d0", tag), rdData1[63:0], d0);
    checkOutput($sformatf("%s byp d1", tag), rdData1[127:64], d1);
    checkOutput($sformatf("%s nobyp d0", tag), rdData0[63:0], d0);
    checkOutput($sformatf("%s nobyp d1", tag), rdData0[127:64], d1);
    checkOutput($sformatf("%s byp busy", tag), 64'(rdBusy1), 64'({b1, b0}));
    checkOutput($sformatf("%s nobyp busy", tag), 64'(rdBusy0), 64'({b1, b0}));
    checkOutput($sformatf("%s byp cnt", tag), 64'(cnt1), 64'(c));
    checkOutput($sformatf("%s nobyp cnt", tag), 64'(cnt0), 64'(c));
  endtask

  initial begin
    //          we     wa0    wd0       wa1    wd1      sb    sa     ra0    ra1    byp: d0     d1    b0    b1    nobyp: d0  d1     b0    b1    cnt
    vecs[0]  = '{2'b01, 5'd5, DB,       5'd0, 64'h0,   1'b0, 5'd0, 5'd5, 5'd5,  DB,      DB,      1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 6'd0};
    vecs[1]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd5, 5'd0,  DB,      64'h0,   1'b0, 1'b0, DB,     64'h0,  1'b0, 1'b0, 6'd0};
    vecs[2]  = '{2'b11, 5'd7, 64'h11,   5'd7, 64'h22,  1'b0, 5'd0, 5'd7, 5'd5,  64'h22,  DB,      1'b0, 1'b0, 64'h0,  DB,     1'b0, 1'b0, 6'd0};
    vecs[3]  = '{2'b01, 5'd0, 64'hFF,   5'd0, 64'h0,   1'b0, 5'd0, 5'd0, 5'd7,  64'h0,   64'h22,  1'b0, 1'b0, 64'h0,  64'h22, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b1, 5'd3, 5'd3, 5'd0,  64'h0,   64'h0,   1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 6'd0};
    vecs[5]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd3, 5'd7,  64'h0,   64'h22,  1'b1, 1'b0, 64'h0,  64'h22, 1'b1, 1'b0, 6'd1};
    vecs[6]  = '{2'b01, 5'd3, 64'h33,   5'd0, 64'h0,   1'b0, 5'd0, 5'd3, 5'd3,  64'h33,  64'h33,  1'b0, 1'b0, 64'h0,  64'h0,  1'b1, 1'b1, 6'd1};
    vecs[7]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd3, 5'd3,  64'h33,  64'h33,  1'b0, 1'b0, 64'h33, 64'h33, 1'b0, 1'b0, 6'd0};
    vecs[8]  = '{2'b10, 5'd0, 64'h0,    5'd9, 64'h55,  1'b1, 5'd9, 5'd9, 5'd7,  64'h55,  64'h22,  1'b1, 1'b0, 64'h0,  64'h22, 1'b0, 1'b0, 6'd0};
    vecs[9]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9,  64'h55,  64'h55,  1'b1, 1'b1, 64'h55, 64'h55, 1'b1, 1'b1, 6'd1};
    vecs[10] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b1, 5'd0, 5'd0, 5'd9,  64'h0,   64'h55,  1'b0, 1'b1, 64'h0,  64'h55, 1'b0, 1'b1, 6'd1};
    vecs[11] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd0, 5'd1,  64'h0,   64'h0,   1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 6'd1};
    vecs[12] = '{2'b11, 5'd1, 64'hA1,   5'd2, 64'hB2,  1'b0, 5'd0, 5'd2, 5'd1,  64'hB2,  64'hA1,  1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 1'b0, 6'd1};
    vecs[13] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,   1'b0, 5'd0, 5'd1, 5'd2,  64'hA1,  64'hB2,  1'b0, 1'b0, 64'hA1, 64'hB2, 1'b0, 1'b0, 6'd1};

    rst = 1'b1;
    rdAddr = '0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every register reads zero and idle straight out of reset.
    for (int a = 0; a < 32; a++) begin
      rdAddr = {5'(a), 5'(a)};
      #1;
      checkReads($sformatf("reset r%0d", a), 64'h0, 64'h0, 1'b0, 1'b0, 6'd0);
    end

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d byp d0", i), rdData1[63:0], vecs[i].b1d0);
      checkOutput($sformatf("v%0d byp d1", i), rdData1[127:64], vecs[i].b1d1);
      checkOutput($sformatf("v%0d byp busy0", i), 64'(rdBusy1[0]), 64'(vecs[i].b1b0));
      checkOutput($sformatf("v%0d byp busy1", i), 64'(rdBusy1[1]), 64'(vecs[i].b1b1));
      checkOutput($sformatf("v%0d nobyp d0", i), rdData0[63:0], vecs[i].b0d0);
      checkOutput($sformatf("v%0d nobyp d1", i), rdData0[127:64], vecs[i].b0d1);
      checkOutput($sformatf("v%0d nobyp busy0", i), 64'(rdBusy0[0]), 64'(vecs[i].b0b0));
      checkOutput($sformatf("v%0d nobyp busy1", i), 64'(rdBusy0[1]), 64'(vecs[i].b0b1));
      checkOutput($sformatf("v%0d byp cnt", i), 64'(cnt1), 64'(vecs[i].eCnt));
      checkOutput($sformatf("v%0d nobyp cnt", i), 64'(cnt0), 64'(vecs[i].eCnt));
    end

    // Mark r1..r4 busy on top of r9, then reset alongside a write and a set.
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk);
      idleInputs();
      setBusy = 1'b1;
      setAddr = 5'(a);
    end
    @(negedge clk);
    idleInputs();
    rdAddr = {5'd9, 5'd2};
    #1;
    checkReads("busy5", 64'hB2, 64'h55, 1'b1, 1'b1, 6'd5);

    @(negedge clk);
    rst = 1'b1;
    we = 2'b01;
    wrAddr = {5'd0, 5'd2};
    wrData = {64'h0, 64'h77};
    setBusy = 1'b1;
    setAddr = 5'd5;
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    rdAddr = {5'd9, 5'd2};
    #1;
    checkReads("rst r2/r9", 64'h0, 64'h0, 1'b0, 1'b0, 6'd0);
    rdAddr = {5'd5, 5'd7};
    #1;
    checkReads("rst r7/r5", 64'h0, 64'h0, 1'b0, 1'b0, 6'd0);

    @(negedge clk);
    rdAddr = {5'd5, 5'd2};
    #1;
    checkReads("post rst", 64'h0, 64'h0, 1'b0, 1'b0, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation core register file: configurable width, depth and number of read/write ports, optional write-to-read bypass, and per-register busy tracking so the issue stage can stall on RAW hazards. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

## Interface
Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, >= 2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports (AW = $clog2(NREGS)):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- rd_addr  in  NRD x AW  read addresses
- rd_data  out  NRD x XLEN  read data (combinational)
- rd_busy  out  NRD x 1  busy flag of addressed register (combinational)
- we  in  NWR x 1  write enables
- wr_addr  in  NWR x AW  write addresses
- wr_data  in  NWR x XLEN  write data
- set_busy  in  1  mark register set_addr busy (issue)
- set_addr  in  AW  destination being issued
- busy_cnt  out  AW+1  number of registers currently busy (registered)

## Operation
- Register 0 is hardwired zero: reads return 0, writes ignored, never busy (set_busy to 0 ignored).
- Write: on edge, for each port p with we[p] and wr_addr[p] != 0, regs[wr_addr[p]] <= wr_data[p]; busy[wr_addr[p]] cleared.
- Write collision (two ports, same nonzero address, same cycle): highest-indexed port wins data; busy cleared once.
- Read: rd_data[i] = regs[rd_addr[i]]. With BYPASS=1, if any enabled write port targets rd_addr[i] (nonzero) this cycle, rd_data[i] = that port's wr_data (highest index wins); rd_busy[i] reflects the clear (0) unless set_busy targets it.
- With BYPASS=0, reads return pre-edge array contents and pre-edge busy.
- Scoreboard: set_busy on edge sets busy[set_addr]. Simultaneous set_busy and write-clear on the same register: set wins (new producer supersedes old result); data still written.
- busy_cnt = popcount of busy vector after the edge; never exceeds NREGS-1.

## Timing
- Reset: all registers 0, all busy bits 0, busy_cnt 0; consequently rd_data = 0 and rd_busy = 0 for every address the cycle after rst high. rst has priority over we and set_busy on the same edge.
- Read latency 0 cycles (combinational from rd_addr); write latency 1 cycle (visible at BYPASS=0 reads the cycle after the edge).
- Busy set visible on rd_busy the cycle after set_busy; busy clear visible same cycle at BYPASS=1, next cycle at BYPASS=0.
- busy_cnt updates 1 cycle after the causing edge, registered, glitch-free.
- Reset asserted mid-operation discards any in-flight write or set in that cycle.

## Structure
- Package regfile_pkg: default XLEN/NREGS constants, reg_addr_t (logic [AW-1:0]) for the default config, and a popcount function.
- One sub-module: regfile_scoreboard (busy vector, set/clear priority, busy_cnt). Top holds the data array, write arbitration and bypass muxes.
- No generate-dependent ports; loops over NRD/NWR via generate/for.

## Test plan
- Reset then read all 32 addresses on both ports -> every rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Write 0xDEAD_BEEF_0000_0001 to r5 via port 0, read r5 same cycle with BYPASS=1 -> 0xDEAD_BEEF_0000_0001; BYPASS=0 -> 0 that cycle, new value next cycle.
- Ports 0 and 1 both write r7 (0x11, 0x22) same edge -> r7 = 0x22; write 0xFF to r0 -> r0 reads 0.
- set_busy r3, next cycle rd_busy=1 and busy_cnt=1; write r3 -> busy clears, busy_cnt=0.
- set_busy r9 and write r9 (0x55) same edge -> r9 = 0x55, busy[9] stays 1, busy_cnt=1.
- Set r1..r4 busy, assert rst with concurrent write to r2 -> all regs 0, busy_cnt 0 next cycle.
